// File: rtl/llc_req_scheduler.sv
// llc_req_scheduler
//   Front-end sequencer for the last-level cache model. Arbitrates L1 processor
//   requests against bus-snoop requests for the single lookup/MESI engine. When
//   the engine asks for it, the scheduler runs one bus transaction and hands the
//   snoop result back to the engine as a fill. It also keeps hit/miss/read/write
//   statistics. Only one transaction is in flight at a time.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   l1_valid/ready/op/addr       L1 request handshake (op 0 rd, 1 wr, 2 ifetch)
//   snp_valid/ready/op/addr      snoop request handshake (op 0..3)
//   lk_valid/op/addr             lookup request to the cache engine
//   lk_done/hit/need_bus/bus_op  lookup result from the engine
//   bus_valid/op/addr            bus transaction request
//   bus_ack/bus_snoop            bus completion and snoop result
//   fill_valid/fill_snoop        snoop result returned to the engine
//   busy                         scheduler not idle
//   clr_stats                    synchronous clear of the statistics counters
//   hit_cnt/miss_cnt/rd_cnt/wr_cnt  saturating statistics counters
module llc_req_scheduler #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l1_valid,
    output logic              l1_ready,
    input  logic [1:0]        l1_op,
    input  logic [ADDR_W-1:0] l1_addr,
    input  logic              snp_valid,
    output logic              snp_ready,
    input  logic [1:0]        snp_op,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              lk_valid,
    output logic [2:0]        lk_op,
    output logic [ADDR_W-1:0] lk_addr,
    input  logic              lk_done,
    input  logic              lk_hit,
    input  logic              lk_need_bus,
    input  logic [1:0]        lk_bus_op,
    output logic              bus_valid,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [1:0]        bus_snoop,
    output logic              fill_valid,
    output logic [1:0]        fill_snoop,
    output logic              busy,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int unsigned    SW         = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, LOOKUP, BUS, FILL} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        bus_op_q, bus_op_d;
    logic [1:0]        snoop_q, snoop_d;
    logic [CNT_W-1:0]  hit_q, miss_q, rd_q, wr_q;
    logic              grant_snp, grant_l1, lk_fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Snoops win by default; a waiting L1 request wins once STARVE_LIM
    // consecutive snoops have been granted over it.
    always_comb begin
        grant_snp = (state_q == IDLE) && snp_valid && !(l1_valid && (starve_q == STARVE_MAX));
        grant_l1  = (state_q == IDLE) && l1_valid && !grant_snp;
        lk_fire   = (state_q == LOOKUP) && lk_done;
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        op_d     = op_q;
        addr_d   = addr_q;
        bus_op_d = bus_op_q;
        snoop_d  = snoop_q;
        unique case (state_q)
            IDLE: begin
                if (grant_snp) begin
                    op_d    = {1'b0, snp_op} + 3'd3;
                    addr_d  = snp_addr;
                    state_d = LOOKUP;
                    if (!l1_valid)
                        starve_d = '0;
                    else if (starve_q != STARVE_MAX)
                        starve_d = starve_q + 1'b1;
                end else if (grant_l1) begin
                    op_d     = {1'b0, l1_op};
                    addr_d   = l1_addr;
                    starve_d = '0;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lk_done) begin
                    if (lk_need_bus) begin
                        bus_op_d = lk_bus_op;
                        state_d  = BUS;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BUS: begin
                if (bus_ack) begin
                    snoop_d = (bus_snoop == 2'd3) ? 2'd0 : bus_snoop;
                    state_d = FILL;
                end
            end
            FILL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            bus_op_q <= '0;
            snoop_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            bus_op_q <= bus_op_d;
            snoop_q  <= snoop_d;
        end
    end

    // Snoop opcodes (3..6) only contribute to hit/miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
        end else if (clr_stats) begin
            hit_q  <= '0;
            miss_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
        end else if (lk_fire) begin
            if (lk_hit) hit_q  <= sat_inc(hit_q);
            else        miss_q <= sat_inc(miss_q);
            if ((op_q == 3'd0) || (op_q == 3'd2)) rd_q <= sat_inc(rd_q);
            if (op_q == 3'd1)                     wr_q <= sat_inc(wr_q);
        end
    end

    assign snp_ready  = grant_snp;
    assign l1_ready   = grant_l1;
    assign lk_valid   = (state_q == LOOKUP);
    assign lk_op      = op_q;
    assign lk_addr    = addr_q;
    assign bus_valid  = (state_q == BUS);
    assign bus_op     = bus_op_q;
    assign bus_addr   = addr_q;
    assign fill_valid = (state_q == FILL);
    assign fill_snoop = snoop_q;
    assign busy       = (state_q != IDLE);
    assign hit_cnt    = hit_q;
    assign miss_cnt   = miss_q;
    assign rd_cnt     = rd_q;
    assign wr_cnt     = wr_q;

endmodule

// File: tb/tb_llc_req_scheduler.sv
module tb_llc_req_scheduler;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        l1_valid, l1_ready;
    logic [1:0]  l1_op;
    logic [31:0] l1_addr;
    logic        snp_valid, snp_ready;
    logic [1:0]  snp_op;
    logic [31:0] snp_addr;
    logic        lk_valid;
    logic [2:0]  lk_op;
    logic [31:0] lk_addr;
    logic        lk_done, lk_hit, lk_need_bus;
    logic [1:0]  lk_bus_op;
    logic        bus_valid;
    logic [1:0]  bus_op;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic [1:0]  bus_snoop;
    logic        fill_valid;
    logic [1:0]  fill_snoop;
    logic        busy;
    logic        clr_stats;
    logic [CW-1:0] hit_cnt, miss_cnt, rd_cnt, wr_cnt;

    int checks   = 0;
    int failures = 0;
    int m_hit, m_miss, m_rd, m_wr;

    always #5 clk = ~clk;

    llc_req_scheduler #(.ADDR_W(32), .CNT_W(CW), .STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst),
        .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_op(l1_op), .l1_addr(l1_addr),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
        .lk_valid(lk_valid), .lk_op(lk_op), .lk_addr(lk_addr),
        .lk_done(lk_done), .lk_hit(lk_hit), .lk_need_bus(lk_need_bus), .lk_bus_op(lk_bus_op),
        .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
        .bus_ack(bus_ack), .bus_snoop(bus_snoop),
        .fill_valid(fill_valid), .fill_snoop(fill_snoop), .busy(busy),
        .clr_stats(clr_stats),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    typedef struct {
        logic        clr;
        logic        l1v;
        logic [1:0]  l1op;
        logic [31:0] l1a;
        logic        sv;
        logic [1:0]  sop;
        logic [31:0] sa;
        logic        exp_l1r;
        logic        exp_sr;
        logic [2:0]  exp_op;
        logic [31:0] exp_addr;
        logic        hit;
        logic        need;
        logic [1:0]  bop;
        int          lat;
        logic [1:0]  bsnp;
        logic [1:0]  exp_fill;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, ".hit_cnt"},  32'(hit_cnt),  32'(m_hit));
        check({tag, ".miss_cnt"}, 32'(miss_cnt), 32'(m_miss));
        check({tag, ".rd_cnt"},   32'(rd_cnt),   32'(m_rd));
        check({tag, ".wr_cnt"},   32'(wr_cnt),   32'(m_wr));
    endtask

    // Runs one complete transaction from IDLE; the engine answers in the first
    // LOOKUP cycle and the bus acks in its lat-th cycle.
    task automatic do_txn(input vec_t v, input string tag);
        if (v.clr) begin
            clr_stats = 1'b1;
            step();
            clr_stats = 1'b0;
            m_hit = 0; m_miss = 0; m_rd = 0; m_wr = 0;
        end
        l1_valid = v.l1v; l1_op = v.l1op; l1_addr = v.l1a;
        snp_valid = v.sv; snp_op = v.sop; snp_addr = v.sa;
        #1;
        check({tag, ".l1_ready"},  32'(l1_ready),  32'(v.exp_l1r));
        check({tag, ".snp_ready"}, 32'(snp_ready), 32'(v.exp_sr));
        step();
        l1_valid = 1'b0; snp_valid = 1'b0;
        check({tag, ".lk_valid"}, 32'(lk_valid), 32'd1);
        check({tag, ".lk_op"},    32'(lk_op),    32'(v.exp_op));
        check({tag, ".lk_addr"},  lk_addr,       v.exp_addr);
        lk_done = 1'b1; lk_hit = v.hit; lk_need_bus = v.need; lk_bus_op = v.bop;
        step();
        lk_done = 1'b0; lk_hit = 1'b0; lk_need_bus = 1'b0; lk_bus_op = 2'd0;
        if (v.hit) m_hit = sat(m_hit); else m_miss = sat(m_miss);
        if (v.exp_op == 3'd0 || v.exp_op == 3'd2) m_rd = sat(m_rd);
        if (v.exp_op == 3'd1) m_wr = sat(m_wr);
        check({tag, ".lk_valid_off"}, 32'(lk_valid), 32'd0);
        if (v.need) begin
            for (int c = 1; c <= v.lat; c++) begin
                check({tag, ".bus_valid"}, 32'(bus_valid), 32'd1);
                check({tag, ".bus_op"},    32'(bus_op),    32'(v.bop));
                check({tag, ".bus_addr"},  bus_addr,       v.exp_addr);
                if (c == v.lat) begin
                    bus_ack = 1'b1; bus_snoop = v.bsnp;
                end
                step();
            end
            bus_ack = 1'b0; bus_snoop = 2'd0;
            check({tag, ".fill_valid"}, 32'(fill_valid), 32'd1);
            check({tag, ".fill_snoop"}, 32'(fill_snoop), 32'(v.exp_fill));
            check({tag, ".bus_valid_off"}, 32'(bus_valid), 32'd0);
            step();
            check({tag, ".fill_valid_off"}, 32'(fill_valid), 32'd0);
        end else begin
            check({tag, ".no_bus"}, 32'(bus_valid), 32'd0);
        end
        check({tag, ".busy_off"}, 32'(busy), 32'd0);
        check_cnts(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        //        clr  l1v l1op   l1a            sv   sop    sa            l1r  sr   op    addr           hit  need bop   lat bsnp  fill
        vecs[0] = '{1'b1,1'b1,2'd0,32'h0000_1040,1'b0,2'd0,32'h0,        1'b1,1'b0,3'd0,32'h0000_1040,1'b1,1'b0,2'd0,0,2'd0,2'd0};
        vecs[1] = '{1'b0,1'b1,2'd1,32'h00AB_C000,1'b0,2'd0,32'h0,        1'b1,1'b0,3'd1,32'h00AB_C000,1'b0,1'b1,2'd3,3,2'd2,2'd2};
        vecs[2] = '{1'b1,1'b0,2'd0,32'h0,        1'b1,2'd0,32'h0000_2000,1'b0,1'b1,3'd3,32'h0000_2000,1'b1,1'b1,2'd1,1,2'd1,2'd1};
        vecs[3] = '{1'b0,1'b1,2'd0,32'h0000_3000,1'b1,2'd3,32'h0000_4000,1'b0,1'b1,3'd6,32'h0000_4000,1'b0,1'b0,2'd0,0,2'd0,2'd0};
        vecs[4] = '{1'b0,1'b1,2'd2,32'h0000_5000,1'b0,2'd0,32'h0,        1'b1,1'b0,3'd2,32'h0000_5000,1'b1,1'b1,2'd0,2,2'd3,2'd0};
        vecs[5] = '{1'b0,1'b0,2'd0,32'h0,        1'b1,2'd2,32'h0000_6000,1'b0,1'b1,3'd5,32'h0000_6000,1'b0,1'b1,2'd2,1,2'd0,2'd0};
        vecs[6] = '{1'b0,1'b1,2'd1,32'hFFFF_FFC0,1'b0,2'd0,32'h0,        1'b1,1'b0,3'd1,32'hFFFF_FFC0,1'b1,1'b0,2'd0,0,2'd0,2'd0};

        m_hit = 0; m_miss = 0; m_rd = 0; m_wr = 0;
        rst = 1'b1;
        l1_valid = 1'b0; l1_op = 2'd0; l1_addr = '0;
        snp_valid = 1'b1; snp_op = 2'd0; snp_addr = '0;
        lk_done = 1'b0; lk_hit = 1'b0; lk_need_bus = 1'b0; lk_bus_op = 2'd0;
        bus_ack = 1'b0; bus_snoop = 2'd0; clr_stats = 1'b0;
        #3;
        check("rst.busy",      32'(busy),      32'd0);
        check("rst.lk_valid",  32'(lk_valid),  32'd0);
        check("rst.bus_valid", 32'(bus_valid), 32'd0);
        check("rst.fill",      32'(fill_valid), 32'd0);
        check("rst.snp_ready", 32'(snp_ready), 32'd1);
        check("rst.l1_ready",  32'(l1_ready),  32'd0);
        check_cnts("rst");
        snp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++)
            do_txn(vecs[i], $sformatf("vec%0d", i));

        // lk_done / bus_ack while idle must be ignored.
        lk_done = 1'b1; lk_hit = 1'b1; bus_ack = 1'b1; bus_snoop = 2'd2;
        step();
        lk_done = 1'b0; lk_hit = 1'b0; bus_ack = 1'b0; bus_snoop = 2'd0;
        check("stray.busy", 32'(busy), 32'd0);
        check("stray.fill", 32'(fill_valid), 32'd0);
        check_cnts("stray");

        // Both requesters held: four snoops, one L1, four snoops, one L1.
        l1_valid = 1'b1; l1_op = 2'd0; l1_addr = 32'h0000_A000;
        snp_valid = 1'b1; snp_addr = 32'h0000_B000;
        for (int g = 0; g < 10; g++) begin
            logic exp_l1;
            logic [1:0] sop;
            exp_l1 = (g == 4) || (g == 9);
            sop = 2'(g % 4);
            snp_op = sop;
            #1;
            check($sformatf("starve%0d.l1_ready", g),  32'(l1_ready),  32'(exp_l1));
            check($sformatf("starve%0d.snp_ready", g), 32'(snp_ready), 32'(!exp_l1));
            step();
            check($sformatf("starve%0d.lk_op", g), 32'(lk_op),
                  exp_l1 ? 32'd0 : 32'(3 + int'(sop)));
            check($sformatf("starve%0d.busy_ready", g), 32'({l1_ready, snp_ready}), 32'd0);
            lk_done = 1'b1; lk_hit = 1'b1;
            step();
            lk_done = 1'b0; lk_hit = 1'b0;
        end
        l1_valid = 1'b0; snp_valid = 1'b0;

        // Reset while a bus transaction is pending.
        l1_valid = 1'b1; l1_op = 2'd0; l1_addr = 32'h0000_7000;
        step();
        l1_valid = 1'b0;
        lk_done = 1'b1; lk_hit = 1'b0; lk_need_bus = 1'b1; lk_bus_op = 2'd0;
        step();
        lk_done = 1'b0; lk_need_bus = 1'b0;
        check("rstbus.bus_valid_pre", 32'(bus_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rstbus.bus_valid", 32'(bus_valid), 32'd0);
        check("rstbus.busy",      32'(busy),      32'd0);
        check("rstbus.fill",      32'(fill_valid), 32'd0);
        check("rstbus.bus_addr",  bus_addr,       32'd0);
        m_hit = 0; m_miss = 0; m_rd = 0; m_wr = 0;
        check_cnts("rstbus");
        bus_ack = 1'b1; bus_snoop = 2'd1;
        step();
        bus_ack = 1'b0; bus_snoop = 2'd0;
        check("rstbus.fill_after", 32'(fill_valid), 32'd0);
        rst = 1'b0;
        step();
        do_txn(vecs[1], "postrst");

        // Saturation: 17 read hits with 4-bit counters.
        vecs[0].clr = 1'b1;
        do_txn(vecs[0], "sat0");
        vecs[0].clr = 1'b0;
        for (int i = 1; i < 17; i++)
            do_txn(vecs[0], $sformatf("sat%0d", i));
        check("sat.hit_cnt_15", 32'(hit_cnt), 32'd15);

        // clr_stats in the same cycle as lk_done wins over the increment.
        l1_valid = 1'b1; l1_op = 2'd1; l1_addr = 32'h0000_8000;
        step();
        l1_valid = 1'b0;
        lk_done = 1'b1; lk_hit = 1'b0; clr_stats = 1'b1;
        step();
        lk_done = 1'b0; clr_stats = 1'b0;
        m_hit = 0; m_miss = 0; m_rd = 0; m_wr = 0;
        check("clrdone.busy", 32'(busy), 32'd0);
        check_cnts("clrdone");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
